// File: rtl/mul_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mul_job_sequencer
//  Purpose  : Front-end for the sequential 32x32 multiplier. Queues operand
//             pairs in a small FIFO, runs one multiplier job at a time through
//             the Reset/Run/Ready handshake, and returns each 64-bit product
//             through a single-entry valid/ack result register. A watchdog
//             aborts a job whose Ready never rises.
//  Ports    : clk, Reset                      - clock, sync active-high reset
//             InValid/InReady/InMultiplicand/InMultiplier - operand push side
//             Count                           - FIFO occupancy
//             MulReset/MulRun/MulMultiplicand/MulMultiplier/MulProduct/MulReady
//                                             - multiplier handshake
//             ResValid/ResAck/ResProduct/ResTimeout - result side
//             Busy                            - a job is in flight
//  Revision : 1.0 - initial release
// ============================================================================
module mul_job_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 100
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         InValid,
    output logic                         InReady,
    input  logic [31:0]                  InMultiplicand,
    input  logic [31:0]                  InMultiplier,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         MulReset,
    output logic                         MulRun,
    output logic [31:0]                  MulMultiplicand,
    output logic [31:0]                  MulMultiplier,
    input  logic [63:0]                  MulProduct,
    input  logic                         MulReady,
    output logic                         ResValid,
    input  logic                         ResAck,
    output logic [63:0]                  ResProduct,
    output logic                         ResTimeout,
    output logic                         Busy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_WD_W  = $clog2(TIMEOUT);

    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_GAP  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [31:0]         r_mem_a [DEPTH];
    logic [31:0]         r_mem_b [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic [c_WD_W-1:0]   r_wd_cnt;
    logic                r_ready_prev;
    logic [31:0]         r_op_a;
    logic [31:0]         r_op_b;
    logic                r_res_valid;
    logic [63:0]         r_res_product;
    logic                r_res_timeout;

    logic                w_push;
    logic                w_launch;
    logic                w_done;
    logic                w_abort;

    assign InReady         = (r_count < c_FULL);
    assign w_push          = InValid && InReady;
    assign Count           = r_count;
    assign MulMultiplicand = r_op_a;
    assign MulMultiplier   = r_op_b;
    assign ResValid        = r_res_valid;
    assign ResProduct      = r_res_product;
    assign ResTimeout      = r_res_timeout;
    assign Busy            = (r_state != S_IDLE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        MulReset = 1'b0;
        MulRun   = 1'b0;
        w_launch = 1'b0;
        w_done   = 1'b0;
        w_abort  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // An ack arriving this edge frees the result slot in time.
                if ((r_count != '0) && (!r_res_valid || ResAck)) begin
                    w_launch = 1'b1;
                    w_next   = S_CLR;
                end
            end
            S_CLR: begin
                MulReset = 1'b1;
                w_next   = S_GAP;
            end
            S_GAP: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                MulRun = 1'b1;
                // Only a true rising edge completes; a Ready left high by a
                // previous job is ignored.
                if (MulReady && !r_ready_prev) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end else if (r_wd_cnt == c_WD_LAST) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FIFO
    // Storage needs no reset: the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= InMultiplicand;
            r_mem_b[r_wr_ptr] <= InMultiplier;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_launch) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_launch})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------------------------------------------- job datapath
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_ready_prev  <= 1'b0;
            r_wd_cnt      <= '0;
            r_res_valid   <= 1'b0;
            r_res_product <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_ready_prev <= MulReady;

            if (w_launch) begin
                r_op_a <= r_mem_a[r_rd_ptr];
                r_op_b <= r_mem_b[r_rd_ptr];
            end

            if (r_state == S_GAP) begin
                r_wd_cnt <= '0;
            end else if ((r_state == S_RUN) && !w_done && !w_abort) begin
                r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
            end

            // A new load on the same edge as an ack takes priority.
            if (w_done) begin
                r_res_valid   <= 1'b1;
                r_res_product <= MulProduct;
                r_res_timeout <= 1'b0;
            end else if (w_abort) begin
                r_res_valid   <= 1'b1;
                r_res_product <= '0;
                r_res_timeout <= 1'b1;
            end else if (ResAck && r_res_valid) begin
                r_res_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
